hangy_autoplayer: RTL and testbench
===================================

// Module: hangy_autoplayer
// PURPOSE
//  Automated player that drives the other end of the game's 6-bit input bus. It issues
//  next pulses with a 5-bit letter code and reads back the 7-bit {lose,win,guessed_letters}
//  status. It scans letter codes FIRST_CHAR..LAST_CHAR, one guess each, and reports the
//  outcome. Used as an on-chip self-play driver and as the bench-side stimulus master.
// PARAMETERS
//  FIRST_CHAR     5'd0   first letter code guessed
//  LAST_CHAR      5'd25  last letter code guessed (>= FIRST_CHAR)
//  SETTLE_CYCLES  8      wait cycles after each next pulse before status is sampled (>= 8)
// PORTS
//  clk          in   1  single clock, rising edge
//  reset        in   1  synchronous, active-high
//  start        in   1  begin a game from IDLE or DONE; ignored while busy
//  game_out     in   7  {lose, win, guessed_letters[4:0]} from the game
//  game_in      out  6  {next, char[4:0]} to the game
//  busy         out  1  high in every state except IDLE and DONE
//  done         out  1  high while in DONE
//  won          out  1  game ended with win (valid while done)
//  lost         out  1  game ended with lose (valid while done)
//  exhausted    out  1  LAST_CHAR evaluated with no win or lose (valid while done)
//  guess_count  out  5  guesses issued this game
//  miss_count   out  4  guesses that left guessed_letters unchanged
//  last_char    out  5  most recent letter code issued
// BEHAVIOUR
//  - Reset (any state, mid-game included): state=IDLE; game_in=0; busy=done=won=lost=exhausted=0;
//    guess_count=0, miss_count=0, last_char=FIRST_CHAR. next is never high outside CLEAR/KICK/PRESENT.
//  - States:
//    IDLE: outputs quiescent. start -> CHECK_END.
//    CHECK_END: clears counters, result flags and char=FIRST_CHAR. If game_out[6] or game_out[5] is
//      high -> CLEAR, else -> KICK.
//    CLEAR: next=1 for exactly one cycle, returning the game from WIN/LOSE to init; then
//      2 wait cycles -> KICK.
//    KICK: next=1 for one cycle, char=0 (init -> word gen); then 2 wait cycles -> PRESENT.
//    PRESENT: next=1 and char for one cycle. prev_letters <= game_out[4:0];
//      guess_count += 1; last_char <= char. -> SETTLE.
//    SETTLE: next=0, char held; count SETTLE_CYCLES cycles -> EVALUATE.
//    EVALUATE (1 cycle, samples game_out):
//      win -> DONE, won=1 (win has priority if both set)
//      lose -> DONE, lost=1
//      else if game_out[4:0]==prev_letters: miss_count += 1
//      then if char==LAST_CHAR -> DONE, exhausted=1; else char += 1 -> PRESENT.
//      A miss that also produces lose is counted.
//    DONE: done=1; result flags and counters held. start -> CHECK_END, which clears them the same cycle.
//  - Each guess occupies exactly 1+SETTLE_CYCLES+1 cycles. The game needs up to 7 cycles to return to
//    guess-wait and 1 more to register win/lose, so SETTLE_CYCLES>=8 is required.
//  - Counters saturate: guess_count at 31, miss_count at 15. The char increment never wraps past LAST_CHAR.
//  - Simultaneous start and reset: reset wins.
//  - start is level-sampled only in IDLE/DONE. Holding it high restarts the next game one cycle after DONE.
// TESTING
//  (game word codes 13,14,19,17,5 map to bits 4..0)
//  1. Defaults, pulse start -> lost=1 when char 8 is evaluated; guess_count=9, miss_count=8,
//     last_char=8, game_out[4:0]=00001.
//  2. FIRST_CHAR=13, LAST_CHAR=19 -> exhausted=1, guess_count=7, miss_count=3, letters=11110,
//     won=lost=0.
//  3. Stub game that reports win and letters=11111 after 3rd guess -> won=1, guess_count=3, done
//     held until the next start.
//  4. start in DONE after a loss -> exactly one CLEAR next pulse, then one KICK pulse, then the first
//     PRESENT; counters read 0 before the first PRESENT.
//  5. reset asserted during SETTLE of guess 4 -> next cycle game_in=0, busy=0, all counters 0.
//  6. Next-pulse checker over all runs -> next never high 2 consecutive cycles; spacing between
//     PRESENT pulses = SETTLE_CYCLES+2.

Source files
------------

// File: rtl/hangy_autoplayer.sv
// Self-play driver for the hangman game. Pulses next with a letter code
// and scans codes FIRST_CHAR..LAST_CHAR until the game reports win or lose.
module hangy_autoplayer #(
  parameter logic [4:0] FIRST_CHAR    = 5'd0,
  parameter logic [4:0] LAST_CHAR     = 5'd25,
  parameter int         SETTLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] game_out,
  output logic [5:0] game_in,
  output logic       busy,
  output logic       done,
  output logic       won,
  output logic       lost,
  output logic       exhausted,
  output logic [4:0] guess_count,
  output logic [3:0] miss_count,
  output logic [4:0] last_char
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_CHECK_END  = 4'd1,
    S_CLEAR      = 4'd2,
    S_CLEAR_WAIT = 4'd3,
    S_KICK       = 4'd4,
    S_KICK_WAIT  = 4'd5,
    S_PRESENT    = 4'd6,
    S_SETTLE     = 4'd7,
    S_EVALUATE   = 4'd8,
    S_DONE       = 4'd9
  } state_t;

  // Current FSM state; kept as a named signal so checkers can bind to it.
  state_t        state;
  logic          next_q;
  logic [4:0]    char_q;
  logic [4:0]    cur_char;
  logic [4:0]    prev_letters;
  logic [1:0]    wait_cnt;
  logic [SW-1:0] settle_cnt;

  logic game_win;
  logic game_lose;
  logic letters_same;

  assign game_win     = game_out[5];
  assign game_lose    = game_out[6];
  assign letters_same = (game_out[4:0] == prev_letters);

  // Protocol: start is a level, taken only in IDLE/DONE. next is a one-cycle
  // pulse carrying char; the game's status is trusted only SETTLE_CYCLES after it.
  assign game_in = {next_q, char_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      next_q       <= 1'b0;
      char_q       <= 5'd0;
      cur_char     <= FIRST_CHAR;
      prev_letters <= 5'd0;
      wait_cnt     <= 2'd0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      won          <= 1'b0;
      lost         <= 1'b0;
      exhausted    <= 1'b0;
      guess_count  <= 5'd0;
      miss_count   <= 4'd0;
      last_char    <= FIRST_CHAR;
    end else begin
      next_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_CHECK_END;
            busy        <= 1'b1;
            done        <= 1'b0;
            won         <= 1'b0;
            lost        <= 1'b0;
            exhausted   <= 1'b0;
            guess_count <= 5'd0;
            miss_count  <= 4'd0;
            cur_char    <= FIRST_CHAR;
          end
        end

        S_CHECK_END: begin
          // A finished game must be bounced back to init before the kick.
          state    <= (game_win || game_lose) ? S_CLEAR : S_KICK;
          next_q   <= 1'b1;
          char_q   <= 5'd0;
          wait_cnt <= 2'd0;
        end

        S_CLEAR: begin
          state <= S_CLEAR_WAIT;
        end

        S_CLEAR_WAIT: begin
          if (wait_cnt == 2'd1) begin
            state    <= S_KICK;
            next_q   <= 1'b1;
            char_q   <= 5'd0;
            wait_cnt <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_KICK: begin
          state <= S_KICK_WAIT;
        end

        S_KICK_WAIT: begin
          if (wait_cnt == 2'd1) begin
            state    <= S_PRESENT;
            next_q   <= 1'b1;
            char_q   <= cur_char;
            wait_cnt <= 2'd0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        S_PRESENT: begin
          prev_letters <= game_out[4:0];
          last_char    <= cur_char;
          if (guess_count != 5'd31) guess_count <= guess_count + 5'd1;
          settle_cnt   <= '0;
          state        <= S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_EVALUATE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_EVALUATE: begin
          // A losing guess is still a miss; a winning one never is.
          if (!game_win && letters_same && miss_count != 4'd15)
            miss_count <= miss_count + 4'd1;
          if (game_win) begin
            won   <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (game_lose) begin
            lost  <= 1'b1;
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (cur_char == LAST_CHAR) begin
            exhausted <= 1'b1;
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            cur_char <= cur_char + 5'd1;
            char_q   <= cur_char + 5'd1;
            next_q   <= 1'b1;
            state    <= S_PRESENT;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hangy_autoplayer.sv
// Bench for hangy_autoplayer: two players (default range and 13..19) each
// drive a small behavioural game whose word is codes {13,14,19,17,5}.
module tb_hangy_autoplayer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst      [2];
  logic       start    [2];
  logic [6:0] gout     [2];
  logic [5:0] gin      [2];
  logic       busy_v   [2];
  logic       done_v   [2];
  logic       won_v    [2];
  logic       lost_v   [2];
  logic       exh_v    [2];
  logic [4:0] gc_v     [2];
  logic [3:0] mc_v     [2];
  logic [4:0] lc_v     [2];

  hangy_autoplayer dut_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .game_out(gout[0]), .game_in(gin[0]),
    .busy(busy_v[0]), .done(done_v[0]), .won(won_v[0]), .lost(lost_v[0]),
    .exhausted(exh_v[0]), .guess_count(gc_v[0]), .miss_count(mc_v[0]), .last_char(lc_v[0])
  );

  hangy_autoplayer #(.FIRST_CHAR(5'd13), .LAST_CHAR(5'd19), .SETTLE_CYCLES(8)) dut_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .game_out(gout[1]), .game_in(gin[1]),
    .busy(busy_v[1]), .done(done_v[1]), .won(won_v[1]), .lost(lost_v[1]),
    .exhausted(exh_v[1]), .guess_count(gc_v[1]), .miss_count(mc_v[1]), .last_char(lc_v[1])
  );

  // ---------------- game model ----------------
  // phase 0 = init, 1 = guessing, 2 = win/lose reported
  logic [1:0] phase   [2];
  logic [4:0] letters [2];
  logic [3:0] misses  [2];
  logic       g_win   [2];
  logic       g_lose  [2];
  logic [1:0] g_n     [2];
  logic       g_rst   [2];
  logic       stub    [2];
  logic [4:0] hm      [2];
  logic [4:0] nl      [2];
  logic [3:0] nm      [2];

  function automatic logic [4:0] word_mask(input logic [4:0] c);
    case (c)
      5'd13:   return 5'b10000;
      5'd14:   return 5'b01000;
      5'd19:   return 5'b00100;
      5'd17:   return 5'b00010;
      5'd5:    return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  assign hm[0]   = word_mask(gin[0][4:0]);
  assign hm[1]   = word_mask(gin[1][4:0]);
  assign nl[0]   = letters[0] | hm[0];
  assign nl[1]   = letters[1] | hm[1];
  assign nm[0]   = misses[0] + ((hm[0] == 5'd0) ? 4'd1 : 4'd0);
  assign nm[1]   = misses[1] + ((hm[1] == 5'd0) ? 4'd1 : 4'd0);
  assign gout[0] = {g_lose[0], g_win[0], letters[0]};
  assign gout[1] = {g_lose[1], g_win[1], letters[1]};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (g_rst[i]) begin
        phase[i] <= 2'd0; letters[i] <= 5'd0; misses[i] <= 4'd0;
        g_win[i] <= 1'b0; g_lose[i] <= 1'b0; g_n[i] <= 2'd0;
      end else if (gin[i][5]) begin
        case (phase[i])
          2'd0: begin
            phase[i] <= 2'd1; letters[i] <= 5'd0; misses[i] <= 4'd0; g_n[i] <= 2'd0;
          end
          2'd1: begin
            if (g_n[i] != 2'd3) g_n[i] <= g_n[i] + 2'd1;
            if (stub[i] && g_n[i] == 2'd2) begin
              letters[i] <= 5'b11111; g_win[i] <= 1'b1; phase[i] <= 2'd2;
            end else begin
              letters[i] <= nl[i];
              misses[i]  <= nm[i];
              if (nl[i] == 5'b11111) begin
                g_win[i] <= 1'b1; phase[i] <= 2'd2;
              end else if (nm[i] == 4'd8) begin
                g_lose[i] <= 1'b1; phase[i] <= 2'd2;
              end
            end
          end
          default: begin
            phase[i] <= 2'd0; g_win[i] <= 1'b0; g_lose[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- next-pulse monitor ----------------
  logic prev_next [2];
  logic have_prev [2];
  int   gap_cnt   [2];
  int   adj_viol  [2];
  int   gap_q[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_next[i] = 1'b0; have_prev[i] = 1'b0; gap_cnt[i] = 0; adj_viol[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      prev_next[i] <= gin[i][5];
      if (rst[i]) begin
        have_prev[i] <= 1'b0;
        gap_cnt[i]   <= 0;
      end else begin
        if (gin[i][5] && prev_next[i]) adj_viol[i] <= adj_viol[i] + 1;
        if (gin[i][5] && phase[i] == 2'd1) begin
          if (have_prev[i]) gap_q.push_back(gap_cnt[i] + 1);
          have_prev[i] <= 1'b1;
          gap_cnt[i]   <= 0;
        end else begin
          gap_cnt[i] <= gap_cnt[i] + 1;
          if (gin[i][5]) have_prev[i] <= 1'b0;
        end
      end
    end
  end

  // ---------------- checking ----------------
  int vectors;
  int miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int i, input string tag);
    int n;
    n = 0;
    while (done_v[i] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_reached"}, {31'd0, done_v[i]}, 32'd1);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  logic [7:0] exp_next_pat;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; g_rst[i] = 1'b1; stub[i] = 1'b0;
    end
    repeat (3) @(negedge clk);

    // reset state; start held high together with reset must be ignored
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("rst_game_in",   {26'd0, gin[0]},    32'd0);
    chk("rst_busy",      {31'd0, busy_v[0]}, 32'd0);
    chk("rst_done",      {31'd0, done_v[0]}, 32'd0);
    chk("rst_guess",     {27'd0, gc_v[0]},   32'd0);
    chk("rst_miss",      {28'd0, mc_v[0]},   32'd0);
    chk("rst_last_a",    {27'd0, lc_v[0]},   32'd0);
    chk("rst_last_b",    {27'd0, lc_v[1]},   32'd13);
    chk("rst_flags",     {29'd0, won_v[0], lost_v[0], exh_v[0]}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; g_rst[i] = 1'b0;
    end
    @(negedge clk);

    // game 1: full scan from code 0, lost on the eighth miss at code 8
    pulse_start(0);
    chk("t1_busy", {31'd0, busy_v[0]}, 32'd1);
    wait_done(0, "t1");
    chk("t1_lost",   {31'd0, lost_v[0]}, 32'd1);
    chk("t1_won",    {31'd0, won_v[0]},  32'd0);
    chk("t1_exh",    {31'd0, exh_v[0]},  32'd0);
    chk("t1_guess",  {27'd0, gc_v[0]},   32'd9);
    chk("t1_miss",   {28'd0, mc_v[0]},   32'd8);
    chk("t1_last",   {27'd0, lc_v[0]},   32'd8);
    chk("t1_letters",{27'd0, gout[0][4:0]}, 32'd1);
    chk("t1_busy_lo",{31'd0, busy_v[0]}, 32'd0);

    // restart from DONE after a loss: CLEAR, KICK, first PRESENT
    exp_next_pat = 8'b1001_0010;  // bit 0 = first cycle after start is taken
    pulse_start(0);
    chk("t4_guess0", {27'd0, gc_v[0]},   32'd0);
    chk("t4_miss0",  {28'd0, mc_v[0]},   32'd0);
    chk("t4_done0",  {31'd0, done_v[0]}, 32'd0);
    chk("t4_lost0",  {31'd0, lost_v[0]}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t4_next_c%0d", k), {31'd0, gin[0][5]}, {31'd0, exp_next_pat[k]});
      if (k < 7) @(negedge clk);
    end
    chk("t4_present_guess", {27'd0, gc_v[0]},      32'd0);
    chk("t4_present_char",  {27'd0, gin[0][4:0]},  32'd0);
    @(negedge clk);
    chk("t4_guess1", {27'd0, gc_v[0]}, 32'd1);
    // start while busy is ignored
    pulse_start(0);
    chk("t4_busy_ign", {31'd0, busy_v[0]}, 32'd1);
    wait_done(0, "t4");
    chk("t4_lost",  {31'd0, lost_v[0]}, 32'd1);
    chk("t4_guess", {27'd0, gc_v[0]},   32'd9);

    // stub game wins on the third guess
    stub[0] = 1'b1;
    pulse_start(0);
    wait_done(0, "t3");
    chk("t3_won",     {31'd0, won_v[0]},  32'd1);
    chk("t3_lost",    {31'd0, lost_v[0]}, 32'd0);
    chk("t3_guess",   {27'd0, gc_v[0]},   32'd3);
    chk("t3_miss",    {28'd0, mc_v[0]},   32'd2);
    chk("t3_letters", {27'd0, gout[0][4:0]}, 32'd31);
    repeat (20) @(negedge clk);
    chk("t3_done_held", {31'd0, done_v[0]}, 32'd1);
    chk("t3_won_held",  {31'd0, won_v[0]},  32'd1);
    pulse_start(0);
    stub[0] = 1'b0;
    chk("t3_done_clr",  {31'd0, done_v[0]}, 32'd0);
    chk("t3_won_clr",   {31'd0, won_v[0]},  32'd0);
    chk("t3_guess_clr", {27'd0, gc_v[0]},   32'd0);

    // reset during SETTLE of guess 4
    begin
      int n;
      n = 0;
      while (gc_v[0] !== 5'd4 && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t5_guess4", {27'd0, gc_v[0]}, 32'd4);
    end
    repeat (2) @(negedge clk);
    chk("t5_settle_next", {31'd0, gin[0][5]}, 32'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("t5_game_in", {26'd0, gin[0]},    32'd0);
    chk("t5_busy",    {31'd0, busy_v[0]}, 32'd0);
    chk("t5_guess",   {27'd0, gc_v[0]},   32'd0);
    chk("t5_miss",    {28'd0, mc_v[0]},   32'd0);
    chk("t5_last",    {27'd0, lc_v[0]},   32'd0);
    @(negedge clk);
    chk("t5_idle_game_in", {26'd0, gin[0]}, 32'd0);

    // narrowed range 13..19 runs out of codes
    pulse_start(1);
    wait_done(1, "t2");
    chk("t2_exh",     {31'd0, exh_v[1]},  32'd1);
    chk("t2_won",     {31'd0, won_v[1]},  32'd0);
    chk("t2_lost",    {31'd0, lost_v[1]}, 32'd0);
    chk("t2_guess",   {27'd0, gc_v[1]},   32'd7);
    chk("t2_miss",    {28'd0, mc_v[1]},   32'd3);
    chk("t2_letters", {27'd0, gout[1][4:0]}, 32'd30);
    chk("t2_last",    {27'd0, lc_v[1]},   32'd19);
    repeat (3) @(negedge clk);
    chk("t2_no_wrap_next", {31'd0, gin[1][5]}, 32'd0);

    // next-pulse monitor results
    chk("t6_adj_a", adj_viol[0], 32'd0);
    chk("t6_adj_b", adj_viol[1], 32'd0);
    chk("t6_gap_count_ok", {31'd0, (gap_q.size() >= 20)}, 32'd1);
    foreach (gap_q[j]) chk($sformatf("t6_gap%0d", j), gap_q[j], 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
